// File: rtl/seq_detect_ctrl.sv
// Run-time configurable serial sequence detector: programmable pattern/length/overlap,
// start/stop arming, Mealy match pulse and a saturating match counter.
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  input  logic              x,
  input  logic              x_valid,
  output logic              busy,
  output logic              z,
  output logic [CNT_W-1:0]  match_count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic              configured;
  logic [MAXLEN-1:0] pat_q;
  logic [LEN_W-1:0]  len_q;
  logic              ovl_q;
  logic [MAXLEN-1:0] history;
  logic [LEN_W-1:0]  collected;

  logic              cfg_ok;
  logic              arm;
  logic [MAXLEN-1:0] window;
  logic [MAXLEN-1:0] mask;
  logic [LEN_W:0]    coll_inc;
  logic              enough_bits;
  logic              match_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W:0] v);
    return (v > (LEN_W+1)'(MAXLEN)) ? LEN_W'(MAXLEN) : v[LEN_W-1:0];
  endfunction

  assign cfg_ok = cfg_valid && (cfg_len != '0) && (cfg_len <= LEN_W'(MAXLEN));

  // Match window: stored history plus the bit arriving this cycle, masked to len bits.
  assign window      = {history[MAXLEN-2:0], x};
  assign coll_inc    = {1'b0, collected} + (LEN_W+1)'(1);
  assign enough_bits = coll_inc >= {1'b0, len_q};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign match_hit = (((window ^ pat_q) & mask) == '0) && enough_bits;
  assign busy      = (state == RUN);
  assign z         = busy & x_valid & match_hit;

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    cfg_ready = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (start && (configured || cfg_ok)) begin
          state_nxt = RUN;
          arm       = 1'b1;
        end
      end
      RUN: begin
        if (stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      configured  <= 1'b0;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      history     <= '0;
      collected   <= '0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && cfg_valid && !cfg_ok;
      if ((state == IDLE) && cfg_ok) begin
        configured <= 1'b1;
        pat_q      <= cfg_pattern;
        len_q      <= cfg_len;
        ovl_q      <= cfg_overlap;
      end
      if (arm) begin
        history     <= '0;
        collected   <= '0;
        match_count <= '0;
      end else if ((state == RUN) && x_valid) begin
        history <= window;
        // Non-overlapping mode restarts the bit count so the next match needs len fresh bits.
        if (match_hit && !ovl_q) collected <= '0;
        else                     collected <= clamp_len(coll_inc);
        if (match_hit) match_count <= sat_inc(match_count);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a default-width instance and a CNT_W=2 instance
// share one stimulus stream and are compared against a behavioural model.
module tb_seq_detect_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       start;
  logic       stop;
  logic       x;
  logic       x_valid;

  logic       cfg_ready, cfg_err, busy, z;
  logic [7:0] match_count;
  logic       cfg_ready_s, cfg_err_s, busy_s, z_s;
  logic [1:0] match_count_s;

  int n_run  = 0;
  int n_fail = 0;

  seq_detect_ctrl #(.MAXLEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(cfg_err), .start(start), .stop(stop), .x(x), .x_valid(x_valid),
    .busy(busy), .z(z), .match_count(match_count)
  );

  seq_detect_ctrl #(.MAXLEN(8), .LEN_W(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(cfg_err_s), .start(start), .stop(stop), .x(x), .x_valid(x_valid),
    .busy(busy_s), .z(z_s), .match_count(match_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic        m_run, m_conf, m_ovl, m_err;
  logic [7:0]  m_pat;
  int          m_len, m_coll, m_cnt;
  logic [31:0] m_hist;
  logic        sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    m_run = 0; m_conf = 0; m_ovl = 0; m_err = 0;
    m_pat = '0; m_len = 0; m_coll = 0; m_cnt = 0; m_hist = '0;
  endtask

  // One clock: push expected z, check combinational outputs before the edge,
  // advance the model across the edge, then check registered outputs.
  task automatic tick();
    logic        hit, ez, ok;
    logic [31:0] w;
    int          l_in;
    w   = {m_hist[30:0], x};
    hit = m_run && x_valid && (m_coll + 1 >= m_len);
    for (int i = 0; i < m_len; i++) if (w[i] != m_pat[i]) hit = 1'b0;
    sb_q.push_back(hit);
    @(negedge clk);
    ez = sb_q.pop_front();
    check_eq("z", z, ez);
    check_eq("z_s", z_s, ez);
    check_eq("cfg_ready", cfg_ready, !m_run);
    check_eq("busy", busy, m_run);
    if (rst) begin
      model_clear();
    end else if (!m_run) begin
      l_in  = int'(cfg_len);
      ok    = cfg_valid && (l_in >= 1) && (l_in <= 8);
      m_err = cfg_valid && !ok;
      if (ok) begin
        m_conf = 1; m_pat = cfg_pattern; m_len = l_in; m_ovl = cfg_overlap;
      end
      if (start && m_conf) begin
        m_run = 1; m_cnt = 0; m_coll = 0; m_hist = '0;
      end
    end else begin
      m_err = 0;
      if (x_valid) begin
        m_hist = w;
        m_coll = (m_coll + 1 > 8) ? 8 : m_coll + 1;
        if (hit) begin
          m_cnt++;
          if (!m_ovl) m_coll = 0;
        end
      end
      if (stop) m_run = 0;
    end
    @(posedge clk);
    #1;
    check_eq("cfg_err", cfg_err, m_err);
    check_eq("busy_after", busy, m_run);
    check_eq("busy_s_after", busy_s, m_run);
    check_eq("count", match_count, sat(m_cnt, 255));
    check_eq("count_s", match_count_s, sat(m_cnt, 3));
  endtask

  task automatic idle_inputs();
    rst = 0; cfg_valid = 0; start = 0; stop = 0; x = 0; x_valid = 0;
  endtask

  task automatic write_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic st);
    cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; start = st;
    tick();
    idle_inputs();
  endtask

  task automatic send(input logic b, input logic v, input logic sp);
    x = b; x_valid = v; stop = sp;
    tick();
    idle_inputs();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], 1'b1, 1'b0);
  endtask

  task automatic do_start();
    start = 1;
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    model_clear();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    tick();

    // Non-overlapping 11101
    write_cfg(8'b11101, 4'd5, 1'b0, 1'b0);
    do_start();
    send_bits(16'b111011101, 9);
    send(1'b0, 1'b0, 1'b1);
    tick();

    // Overlapping 11101 (config and start together), then overlapping 101
    write_cfg(8'b11101, 4'd5, 1'b1, 1'b1);
    send_bits(16'b111011101, 9);
    send(1'b0, 1'b0, 1'b1);
    write_cfg(8'b101, 4'd3, 1'b1, 1'b1);
    send_bits(16'b111011101, 9);
    send(1'b0, 1'b0, 1'b1);

    // 101 non-overlap vs overlap on 10101
    write_cfg(8'b101, 4'd3, 1'b0, 1'b1);
    send_bits(16'b10101, 5);
    send(1'b0, 1'b0, 1'b1);
    write_cfg(8'b101, 4'd3, 1'b1, 1'b1);
    send_bits(16'b10101, 5);
    send(1'b0, 1'b0, 1'b1);

    // Illegal lengths with no prior valid config
    do_reset();
    write_cfg(8'hA5, 4'd0, 1'b0, 1'b0);
    tick();
    write_cfg(8'hA5, 4'd9, 1'b0, 1'b0);
    tick();
    do_start();
    write_cfg(8'h01, 4'd9, 1'b0, 1'b1);
    tick();

    // Bubbles, config attempt during RUN, stop with the final bit
    write_cfg(8'b110, 4'd3, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    cfg_valid = 1; cfg_pattern = 8'hFF; cfg_len = 4'd0; cfg_overlap = 1;
    tick();
    idle_inputs();
    cfg_valid = 1; cfg_pattern = 8'h01; cfg_len = 4'd1; start = 1;
    tick();
    idle_inputs();
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    tick();
    do_start();
    send_bits(16'b1101, 4);
    send(1'b0, 1'b0, 1'b1);

    // Saturation of the narrow counter, then reset mid-RUN
    write_cfg(8'b1, 4'd1, 1'b1, 1'b1);
    send_bits(16'b111111, 6);
    x = 1; x_valid = 1; rst = 1;
    tick();
    idle_inputs();
    do_start();
    tick();

    // Random stream with a random 4-bit pattern
    write_cfg(8'($urandom_range(0, 15)), 4'd4, 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 60; i++) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
    send(1'b0, 1'b0, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
